// File: rtl/div_operand_acc.sv
// div_operand_acc: groups signed samples into a held (sum, count) pair for a mean divider; DIV_ACC_SAT_EN saturates the sum on overflow
module div_operand_acc #(
    parameter int N = 32,
    parameter int M = 28,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] g_input,
    output logic [M-1:0] e_input,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    localparam logic [M-1:0] CMAX = {1'b0, {(M-1){1'b1}}};
    state_t state_q, state_d;
    logic [N-1:0] sum_q, sum_d, add, raw;
    logic [M-1:0] cnt_q, cnt_d, cnt_inc;
    logic ovf_q, ovf_d, accept, of;
    assign in_ready = !rst && state_q != HOLD;
    assign accept = in_valid && in_ready;
    assign add = N'($signed(in_data));
    assign raw = sum_q + add;
    assign cnt_inc = cnt_q + M'(1);
    assign of = sum_q[N-1] == add[N-1] && raw[N-1] != sum_q[N-1];
    assign out_valid = state_q == HOLD;
    assign g_input = sum_q;
    assign e_input = {1'b0, cnt_q[M-2:0]};
    assign ovf = ovf_q;
    // sum and count are zero in IDLE, so the first sample needs no separate load path
    always_comb begin
        state_d = state_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == HOLD) begin
            if (out_ready) begin
                state_d = IDLE;
                sum_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        end else if (accept) begin
`ifdef DIV_ACC_SAT_EN
            sum_d = of ? {sum_q[N-1], {(N-1){!sum_q[N-1]}}} : raw;
`else
            sum_d = raw;
`endif
            cnt_d = cnt_inc;
            ovf_d = ovf_q | of;
            state_d = (in_last || cnt_inc == CMAX) ? HOLD : ACC;
        end
    end
    // state and group registers; reset discards any partial or pending group
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_div_operand_acc.sv
// tb_div_operand_acc: directed checks of grouping, handshake, overflow, count cap and reset
module tb_div_operand_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic va = 1'b0, la = 1'b0, ra = 1'b1, vb = 1'b0, lb = 1'b0, rb = 1'b1;
    logic [15:0] da = '0, db = '0;
    logic ira, ova, ofa, irb, ovb, ofb;
    logic signed [19:0] ga;
    logic [27:0] ea;
    logic signed [31:0] gb;
    logic [3:0] eb;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    div_operand_acc #(.N(20), .M(28), .W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(ira), .in_data(da), .in_last(la),
        .out_valid(ova), .out_ready(ra), .g_input(ga), .e_input(ea), .ovf(ofa)
    );
    div_operand_acc #(.N(32), .M(4), .W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(irb), .in_data(db), .in_last(lb),
        .out_valid(ovb), .out_ready(rb), .g_input(gb), .e_input(eb), .ovf(ofb)
    );
    task automatic send(input bit s, input int d, input bit last);
        int n;
        n = 0;
        if (s) begin vb = 1'b1; db = 16'(d); lb = last; end
        else begin va = 1'b1; da = 16'(d); la = last; end
        while (!(s ? irb : ira) && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL send_timeout: in_ready got 0 expected 1"); end
        @(negedge clk);
        if (s) begin vb = 1'b0; lb = 1'b0; end
        else begin va = 1'b0; la = 1'b0; end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ira !== 1'b0 || irb !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b%b expected 00", ira, irb); end
        total++; if (ova !== 1'b0 || ofa !== 1'b0) begin bad++; $display("FAIL rst_valid_ovf: got %b%b expected 00", ova, ofa); end
        total++; if (ga !== 0 || ea !== 0) begin bad++; $display("FAIL rst_pair: got (%0d,%0d) expected (0,0)", ga, ea); end
        rst = 1'b0;
        #1;
        total++; if (ira !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b expected 1", ira); end
    endtask
    task automatic test_basic;
        send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 1);
        total++; if (ova !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b expected 1", ova); end
        total++; if (ga !== 100 || ea !== 4) begin bad++; $display("FAIL basic_pair: got (%0d,%0d) expected (100,4)", ga, ea); end
        total++; if (ofa !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b expected 0", ofa); end
        @(negedge clk);
        total++; if (ova !== 1'b0 || ira !== 1'b1) begin bad++; $display("FAIL basic_release: valid/ready got %b%b expected 01", ova, ira); end
        total++; if (ga !== 0 || ea !== 0) begin bad++; $display("FAIL basic_clear: got (%0d,%0d) expected (0,0)", ga, ea); end
    endtask
    task automatic test_neg_single;
        send(0, -66, 1);
        total++; if (ova !== 1'b1 || ga !== -66 || ea !== 1) begin bad++; $display("FAIL neg_single: got v=%b (%0d,%0d) expected v=1 (-66,1)", ova, ga, ea); end
        @(negedge clk);
        send(0, 71, 0); send(0, 71, 1);
        total++; if (ova !== 1'b1 || ga !== 142 || ea !== 2) begin bad++; $display("FAIL pair_142: got v=%b (%0d,%0d) expected v=1 (142,2)", ova, ga, ea); end
        @(negedge clk);
    endtask
    task automatic test_backpressure;
        ra = 1'b0;
        send(0, 5, 0); send(0, 7, 1);
        va = 1'b1; da = 16'd9; la = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ira !== 1'b0 || ova !== 1'b1 || ga !== 12 || ea !== 2) begin
                bad++; $display("FAIL bp_hold%0d: got rdy=%b v=%b (%0d,%0d) expected rdy=0 v=1 (12,2)", i, ira, ova, ga, ea);
            end
            @(negedge clk);
        end
        ra = 1'b1;
        @(negedge clk);
        total++; if (ira !== 1'b1 || ova !== 1'b0) begin bad++; $display("FAIL bp_idle: rdy/valid got %b%b expected 10", ira, ova); end
        @(negedge clk);
        va = 1'b0; la = 1'b0;
        total++; if (ova !== 1'b1 || ga !== 9 || ea !== 1) begin bad++; $display("FAIL bp_accept: got v=%b (%0d,%0d) expected v=1 (9,1)", ova, ga, ea); end
        @(negedge clk);
    endtask
    task automatic test_overflow;
        int exp_g;
`ifdef DIV_ACC_SAT_EN
        exp_g = 524287;
`else
        exp_g = 262104;
`endif
        repeat (39) send(0, 32767, 0);
        send(0, 32767, 1);
        total++; if (ofa !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", ofa); end
        total++; if (ga !== exp_g || ea !== 40) begin bad++; $display("FAIL ovf_pair: got (%0d,%0d) expected (%0d,40)", ga, ea, exp_g); end
        @(negedge clk);
        total++; if (ofa !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b expected 0", ofa); end
    endtask
    task automatic test_count_cap;
        repeat (7) send(1, 1, 0);
        total++; if (ovb !== 1'b1 || gb !== 7 || eb !== 7) begin bad++; $display("FAIL cap_pair: got v=%b (%0d,%0d) expected v=1 (7,7)", ovb, gb, eb); end
        repeat (2) send(1, 1, 0);
        total++; if (ovb !== 1'b0 || irb !== 1'b1 || gb !== 2 || eb !== 2) begin bad++; $display("FAIL cap_partial: got v=%b rdy=%b (%0d,%0d) expected v=0 rdy=1 (2,2)", ovb, irb, gb, eb); end
        send(1, 1, 1);
        total++; if (ovb !== 1'b1 || gb !== 3 || eb !== 3 || ofb !== 1'b0) begin bad++; $display("FAIL cap_tail: got v=%b ovf=%b (%0d,%0d) expected v=1 ovf=0 (3,3)", ovb, ofb, gb, eb); end
        @(negedge clk);
    endtask
    task automatic test_reset_mid;
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (ira !== 1'b0 || ova !== 1'b0 || ga !== 0 || ea !== 0) begin bad++; $display("FAIL mid_rst: got rdy=%b v=%b (%0d,%0d) expected rdy=0 v=0 (0,0)", ira, ova, ga, ea); end
        rst = 1'b0;
        #1;
        total++; if (ira !== 1'b1) begin bad++; $display("FAIL mid_release: in_ready got %b expected 1", ira); end
        send(0, 5, 1);
        total++; if (ova !== 1'b1 || ga !== 5 || ea !== 1) begin bad++; $display("FAIL mid_pair: got v=%b (%0d,%0d) expected v=1 (5,1)", ova, ga, ea); end
        @(negedge clk);
    endtask
    initial begin
        test_reset;
        test_basic;
        test_neg_single;
        test_backpressure;
        test_overflow;
        test_count_cap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
